uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_parity_calc.sv | 13 +
 rtl/uart_rx_fsm.sv | 143 ++++++++++++++
 tb/tb_uart_rx_fsm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared defaults and state encoding for the UART receive FSM
package uart_rx_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_PRESCALE_LAST = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - expected parity bit for a received data word
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    // Odd parity inverts the plain XOR so the total count of ones comes out odd.
    assign parity = (^data) ^ par_typ;

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive frame controller driving the edge/bit counter and sampler
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_LAST = DEFAULT_PRESCALE_LAST
) (
    input  logic                  clk,
    input  logic                  asy_reset,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [3:0]            edge_count,
    input  logic [4:0]            bit_count,
    input  logic                  sampled_bit,
    output logic                  edge_bit_enable,
    output logic                  sample_enable,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    rx_state_t             state, next_state;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  par_en_q, par_en_next;
    logic                  par_typ_q, par_typ_next;
    logic                  par_flag, par_flag_next;
    logic                  stp_flag, stp_flag_next;
    logic                  bit_end;
    logic                  expected_parity;
    logic                  frame_end;
    logic                  frame_good;
    logic                  run_next;

    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data    (shift_reg),
        .par_typ (par_typ_q),
        .parity  (expected_parity)
    );

    assign bit_end = (edge_count == 4'(PRESCALE_LAST));

    always_comb begin
        next_state    = state;
        shift_next    = shift_reg;
        par_en_next   = par_en_q;
        par_typ_next  = par_typ_q;
        par_flag_next = par_flag;
        stp_flag_next = stp_flag;
        case (state)
            ST_IDLE: begin
                // Frame configuration is frozen here so mid-frame changes cannot corrupt it.
                if (!RX_IN) begin
                    next_state    = ST_START;
                    par_en_next   = PAR_EN;
                    par_typ_next  = PAR_TYP;
                    par_flag_next = 1'b0;
                    stp_flag_next = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    next_state = sampled_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_next = {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_count == 5'(DATA_WIDTH)) begin
                        next_state = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    if (sampled_bit != expected_parity) begin
                        par_flag_next = 1'b1;
                    end
                    next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!sampled_bit) begin
                        stp_flag_next = 1'b1;
                    end
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    assign frame_end  = (state == ST_STOP) && (next_state == ST_DONE);
    assign frame_good = frame_end && !par_flag_next && !stp_flag_next;
    assign run_next   = (next_state == ST_START) || (next_state == ST_DATA) ||
                        (next_state == ST_PARITY) || (next_state == ST_STOP);

    always_ff @(posedge clk or posedge asy_reset) begin
        if (asy_reset) begin
            state           <= ST_IDLE;
            shift_reg       <= '0;
            par_en_q        <= 1'b0;
            par_typ_q       <= 1'b0;
            par_flag        <= 1'b0;
            stp_flag        <= 1'b0;
            P_DATA          <= '0;
            data_valid      <= 1'b0;
            par_err         <= 1'b0;
            stp_err         <= 1'b0;
            busy            <= 1'b0;
            edge_bit_enable <= 1'b0;
            sample_enable   <= 1'b0;
        end else begin
            state           <= next_state;
            shift_reg       <= shift_next;
            par_en_q        <= par_en_next;
            par_typ_q       <= par_typ_next;
            par_flag        <= par_flag_next;
            stp_flag        <= stp_flag_next;
            data_valid      <= frame_good;
            par_err         <= frame_end && par_flag_next;
            stp_err         <= frame_end && stp_flag_next;
            busy            <= (next_state != ST_IDLE);
            edge_bit_enable <= run_next;
            sample_enable   <= run_next;
            if (frame_good) begin
                P_DATA <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - self-checking bench for uart_rx_fsm
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       asy_reset;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [3:0] edge_count;
    logic [4:0] bit_count;
    logic       sampled_bit;
    logic       edge_bit_enable;
    logic       sample_enable;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    uart_rx_fsm dut (
        .clk             (clk),
        .asy_reset       (asy_reset),
        .RX_IN           (RX_IN),
        .PAR_EN          (PAR_EN),
        .PAR_TYP         (PAR_TYP),
        .edge_count      (edge_count),
        .bit_count       (bit_count),
        .sampled_bit     (sampled_bit),
        .edge_bit_enable (edge_bit_enable),
        .sample_enable   (sample_enable),
        .P_DATA          (P_DATA),
        .data_valid      (data_valid),
        .par_err         (par_err),
        .stp_err         (stp_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic       check_en = 1'b0;
    logic       exp_busy, exp_en, exp_dv, exp_pe, exp_se;
    logic [7:0] exp_pdata;
    int         dv_seen = 0;
    int         pe_seen = 0;
    int         se_seen = 0;
    logic [7:0] dv_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expectations are set at a negedge for the cycle that follows the next posedge.
    task automatic set_exp(input logic b, input logic en, input logic dv, input logic pe, input logic se);
        exp_busy = b;
        exp_en   = en;
        exp_dv   = dv;
        exp_pe   = pe;
        exp_se   = se;
    endtask

    always @(posedge clk) begin
        #1;
        if (check_en) begin
            chk("busy", busy, exp_busy);
            chk("edge_bit_enable", edge_bit_enable, exp_en);
            chk("sample_enable", sample_enable, exp_en);
            chk("data_valid", data_valid, exp_dv);
            chk("par_err", par_err, exp_pe);
            chk("stp_err", stp_err, exp_se);
            chk("P_DATA", P_DATA, exp_pdata);
        end
        if (data_valid) begin
            dv_seen++;
            dv_data.push_back(P_DATA);
        end
        if (par_err) pe_seen++;
        if (stp_err) se_seen++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            RX_IN       = 1'b1;
            PAR_EN      = 1'($urandom);
            PAR_TYP     = 1'($urandom);
            edge_count  = 4'($urandom_range(0, 7));
            bit_count   = 5'($urandom_range(0, 10));
            sampled_bit = 1'($urandom);
            set_exp(0, 0, 0, 0, 0);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pen, input logic ptyp,
                              input logic bad_par, input logic stop_bit, input logic b2b,
                              input int abort_bit);
        logic [11:0] bits;
        int          nbits;
        logic        pbit, perr, serr, good;
        pbit = (^data) ^ ptyp ^ bad_par;
        bits = '0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        if (pen) begin
            bits[9]  = pbit;
            bits[10] = stop_bit;
            nbits    = 11;
        end else begin
            bits[9]  = stop_bit;
            nbits    = 10;
        end
        // Even parity wants an even count of ones over data+parity; odd wants an odd count.
        perr = pen && (((^data) ^ pbit) != ptyp);
        serr = !stop_bit;
        good = !perr && !serr;

        @(negedge clk);
        RX_IN       = 1'b0;
        PAR_EN      = pen;
        PAR_TYP     = ptyp;
        edge_count  = 4'd0;
        bit_count   = 5'd0;
        sampled_bit = 1'($urandom);
        set_exp(1, 1, 0, 0, 0);
        for (int b = 0; b < nbits; b++) begin
            for (int e = 0; e < 8; e++) begin
                @(negedge clk);
                if (b == abort_bit) begin
                    set_exp(0, 0, 0, 0, 0);
                    exp_pdata = 8'h00;
                    asy_reset = 1'b1;
                    #1;
                    chk("abort_busy", busy, 1'b0);
                    chk("abort_enable", edge_bit_enable, 1'b0);
                    chk("abort_pdata", P_DATA, 8'h00);
                    @(negedge clk);
                    asy_reset = 1'b0;
                    RX_IN     = 1'b1;
                    return;
                end
                edge_count  = 4'(e);
                bit_count   = 5'(b);
                RX_IN       = bits[b];
                sampled_bit = (e == 7) ? bits[b] : 1'($urandom);
                if (b == 3 && e == 0) begin
                    PAR_EN  = ~pen;
                    PAR_TYP = ~ptyp;
                end
                if (b == nbits - 1 && e == 7) begin
                    set_exp(1, 0, good, perr, serr);
                    if (good) exp_pdata = data;
                end else begin
                    set_exp(1, 1, 0, 0, 0);
                end
            end
        end
        @(negedge clk);
        RX_IN      = b2b ? 1'b0 : 1'b1;
        edge_count = 4'd0;
        bit_count  = 5'd0;
        set_exp(0, 0, 0, 0, 0);
    endtask

    task automatic start_glitch();
        @(negedge clk);
        RX_IN       = 1'b0;
        edge_count  = 4'd0;
        bit_count   = 5'd0;
        sampled_bit = 1'b0;
        set_exp(1, 1, 0, 0, 0);
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            edge_count  = 4'(e);
            RX_IN       = (e < 2) ? 1'b0 : 1'b1;
            sampled_bit = (e == 7) ? 1'b1 : 1'b0;
            if (e == 7) set_exp(0, 0, 0, 0, 0);
            else        set_exp(1, 1, 0, 0, 0);
        end
    endtask

    initial begin
        asy_reset   = 1'b1;
        RX_IN       = 1'b1;
        PAR_EN      = 1'b0;
        PAR_TYP     = 1'b0;
        edge_count  = 4'd0;
        bit_count   = 5'd0;
        sampled_bit = 1'b0;
        set_exp(0, 0, 0, 0, 0);
        exp_pdata = 8'h00;
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_data_valid", data_valid, 1'b0);
        chk("reset_pdata", P_DATA, 8'h00);
        chk("reset_enables", {edge_bit_enable, sample_enable}, 2'b00);
        chk("reset_errors", {par_err, stp_err}, 2'b00);
        repeat (2) @(negedge clk);
        asy_reset = 1'b0;
        check_en  = 1'b1;
        idle(3);

        send_frame(8'hA5, 0, 0, 0, 1, 0, -1);
        idle(2);
        chk("a5_pdata", P_DATA, 8'hA5);
        chk("a5_dv_count", dv_seen, 1);
        chk("a5_err_count", pe_seen + se_seen, 0);

        send_frame(8'h3C, 1, 0, 0, 1, 0, -1);
        idle(2);
        chk("3c_even_pdata", P_DATA, 8'h3C);
        chk("3c_even_dv_count", dv_seen, 2);

        send_frame(8'h5A, 1, 1, 0, 1, 0, -1);
        idle(2);
        chk("5a_odd_pdata", P_DATA, 8'h5A);

        send_frame(8'h3C, 1, 0, 1, 1, 0, -1);
        idle(2);
        chk("3c_badpar_pe_count", pe_seen, 1);
        chk("3c_badpar_dv_count", dv_seen, 3);
        chk("3c_badpar_pdata_kept", P_DATA, 8'h5A);

        start_glitch();
        idle(3);
        chk("glitch_counts", dv_seen + pe_seen + se_seen, 4);
        chk("glitch_busy", busy, 1'b0);

        send_frame(8'h81, 0, 0, 0, 0, 0, -1);
        idle(2);
        chk("81_se_count", se_seen, 1);
        chk("81_dv_count", dv_seen, 3);

        send_frame(8'h0F, 1, 1, 1, 0, 0, -1);
        idle(2);
        chk("both_err_counts", {pe_seen[7:0], se_seen[7:0]}, 16'h0202);

        send_frame(8'h12, 0, 0, 0, 1, 1, -1);
        send_frame(8'h34, 0, 0, 0, 1, 0, -1);
        idle(2);
        chk("b2b_dv_count", dv_seen, 5);
        if (dv_data.size() >= 2) begin
            chk("b2b_first", dv_data[dv_data.size()-2], 8'h12);
            chk("b2b_second", dv_data[dv_data.size()-1], 8'h34);
        end else begin
            chk("b2b_queue_size", dv_data.size(), 5);
        end

        send_frame(8'hC3, 0, 0, 0, 1, 0, 4);
        idle(3);
        chk("abort_no_pulse", dv_seen + pe_seen + se_seen, 9);
        send_frame(8'h55, 0, 0, 0, 1, 0, -1);
        idle(2);
        chk("55_pdata", P_DATA, 8'h55);
        chk("55_dv_count", dv_seen, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
